// File: rtl/bank_pkg.sv
// Shared bank-level types and sizes for the linefill buffer slice.
package bank_pkg;

  localparam int LFB_ENTRY_AW = 6;
  localparam int LFB_BEAT_W   = 128;

  typedef enum logic [1:0] {
    LFB_EMPTY = 2'd0,
    LFB_HALF  = 2'd1,
    LFB_FULL  = 2'd2
  } lfb_state_e;

endpackage

// File: rtl/bank_lfb_entry.sv
// One linefill slot: EMPTY/HALF/FULL state plus a two-beat line store.
import bank_pkg::*;

module bank_lfb_entry #(
  parameter int BEAT_W = LFB_BEAT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_lo_i,
  input  logic                wr_hi_i,
  input  logic [BEAT_W-1:0]   wdata_i,
  input  logic                release_i,
  output lfb_state_e          state_o,
  output logic [2*BEAT_W-1:0] data_o
);

  lfb_state_e          state_q, state_d;
  logic [2*BEAT_W-1:0] data_q;

  // Release has priority; the top never raises a write together with a release.
  always_comb begin
    state_d = state_q;
    if (release_i)    state_d = LFB_EMPTY;
    else if (wr_hi_i) state_d = LFB_FULL;
    else if (wr_lo_i) state_d = LFB_HALF;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LFB_EMPTY;
    else       state_q <= state_d;
  end

  // Line storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_lo_i) data_q[BEAT_W-1:0]        <= wdata_i;
    if (wr_hi_i) data_q[2*BEAT_W-1:BEAT_W] <= wdata_i;
  end

  assign state_o = state_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bank_linefill_buffer.sv
// Per-bank linefill buffer: assembles two BIU beats per slot and notifies the issue queue.
// Define LFB_PROTO_CHK_EN to enable beat-ordering checks and the sticky lfb_err_o flag.
import bank_pkg::*;

module bank_linefill_buffer #(
  parameter int ENTRY_AW = LFB_ENTRY_AW,
  parameter int BEAT_W   = LFB_BEAT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                biu_lfb_rvalid_i,
  output logic                biu_lfb_rready_o,
  input  logic [ENTRY_AW-1:0] biu_lfb_rid_i,
  input  logic [BEAT_W-1:0]   biu_lfb_rdata_i,
  input  logic                biu_lfb_rlast_i,
  output logic                biu_isu_rvalid_o,
  output logic [ENTRY_AW-1:0] biu_isu_rid_o,
  input  logic [ENTRY_AW-1:0] iq_linefill_buffer_raddr_i,
  output logic [2*BEAT_W-1:0] linefill_buffer_data_o,
  input  logic                sc_lfb_release_valid_i,
  input  logic [ENTRY_AW-1:0] sc_lfb_release_id_i,
  output logic [ENTRY_AW:0]   lfb_busy_cnt_o,
  output logic                lfb_err_o
);

  localparam int NUM = 1 << ENTRY_AW;

  lfb_state_e          slot_state [NUM];
  logic [2*BEAT_W-1:0] slot_data  [NUM];
  logic [NUM-1:0]      wr_lo, wr_hi, rel;

  lfb_state_e cur_state, rel_state;
  logic       beat_acc, rel_hit, proto_bad, beat_ok, inc, dec;

  logic                notify_q;
  logic [ENTRY_AW-1:0] notify_id_q;
  logic [ENTRY_AW:0]   cnt_q, cnt_d;

  assign cur_state        = slot_state[biu_lfb_rid_i];
  assign rel_state        = slot_state[sc_lfb_release_id_i];
  assign biu_lfb_rready_o = (cur_state != LFB_FULL);
  assign beat_acc         = biu_lfb_rvalid_i & biu_lfb_rready_o;
  assign rel_hit          = sc_lfb_release_valid_i & (sc_lfb_release_id_i == biu_lfb_rid_i);

`ifdef LFB_PROTO_CHK_EN
  logic err_q;

  assign proto_bad = biu_lfb_rlast_i ? (cur_state != LFB_HALF) : (cur_state != LFB_EMPTY);

  always_ff @(posedge clk_i) begin
    if (rst_i)                                err_q <= 1'b0;
    else if (beat_acc & (rel_hit | proto_bad)) err_q <= 1'b1;
  end

  assign lfb_err_o = err_q;
`else
  assign proto_bad = 1'b0;
  assign lfb_err_o = 1'b0;
`endif

  // A release to the targeted slot always wins over the beat.
  assign beat_ok = beat_acc & ~rel_hit & ~proto_bad;
  assign inc     = beat_ok & (cur_state == LFB_EMPTY);
  assign dec     = sc_lfb_release_valid_i & (rel_state != LFB_EMPTY);

  for (genvar i = 0; i < NUM; i++) begin : g_slot
    assign wr_lo[i] = beat_ok & ~biu_lfb_rlast_i & (biu_lfb_rid_i == ENTRY_AW'(i));
    assign wr_hi[i] = beat_ok &  biu_lfb_rlast_i & (biu_lfb_rid_i == ENTRY_AW'(i));
    assign rel[i]   = sc_lfb_release_valid_i & (sc_lfb_release_id_i == ENTRY_AW'(i));

    bank_lfb_entry #(.BEAT_W(BEAT_W)) u_entry (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_lo_i   (wr_lo[i]),
      .wr_hi_i   (wr_hi[i]),
      .wdata_i   (biu_lfb_rdata_i),
      .release_i (rel[i]),
      .state_o   (slot_state[i]),
      .data_o    (slot_data[i])
    );
  end

  assign linefill_buffer_data_o = slot_data[iq_linefill_buffer_raddr_i];

  // Notify fires the cycle after the upper beat lands, when both halves are readable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      notify_q    <= 1'b0;
      notify_id_q <= '0;
    end else begin
      notify_q <= beat_ok & biu_lfb_rlast_i;
      if (beat_ok & biu_lfb_rlast_i) notify_id_q <= biu_lfb_rid_i;
    end
  end

  assign biu_isu_rvalid_o = notify_q;
  assign biu_isu_rid_o    = notify_id_q;

  assign cnt_d = cnt_q + {{ENTRY_AW{1'b0}}, inc} - {{ENTRY_AW{1'b0}}, dec};

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign lfb_busy_cnt_o = cnt_q;

endmodule
